// File: rtl/spi_hls_bridge.sv
// SPI byte-command bridge for an HLS accelerator: loads/reads per-channel word memories,
// starts the core, and returns status and captured result words over the SPI response path.
module spi_hls_bridge #(
    parameter int  DATA_W     = 32,
    parameter int  DEPTH      = 10,
    parameter int  NUM_CH     = 2,
    parameter int  NUM_RES    = 2,
    parameter int  AUTO_START = 1,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx_valid,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_ss_n,
    output logic                      o_tx_valid,
    output logic [7:0]                o_tx_data,
    output logic [CW-1:0]             o_mem_ch,
    output logic [AW-1:0]             o_mem_addr,
    output logic                      o_mem_we,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata,
    output logic                      o_ap_start,
    input  logic                      i_ap_ready,
    input  logic                      i_ap_done,
    input  logic                      i_ap_idle,
    input  logic [NUM_RES*DATA_W-1:0] i_result,
    input  logic [NUM_RES-1:0]        i_result_vld
);
    localparam int BYTES = DATA_W / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int RW    = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

    typedef enum logic [2:0] {IDLE, ARG, WRITE, READ, STATUS, RESULT} state_e;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_RES} op_e;

    state_e                           state_q, state_d;
    op_e                              op_q, op_d;
    logic [BW-1:0]                    byte_q;
    logic [AW-1:0]                    word_q;
    logic [DATA_W-1:0]                rd_word, rd_nxt;
    logic [DATA_W+7:0]                wr_cat;
    logic [1:0]                       rd_pipe;
    logic                             done_q, err_q;
    logic [NUM_RES-1:0][DATA_W-1:0]   res_q;
    logic                             rx, byte_last, word_last, busy;
    logic                             bad, trig, trig_ok, wr_word, rd_issue, stat_clr;

    assign rx        = i_rx_valid & ~i_ss_n;
    assign byte_last = (byte_q == BW'(BYTES - 1));
    assign word_last = (word_q == AW'(DEPTH - 1));
    assign busy      = o_ap_start | ~i_ap_idle;
    assign trig_ok   = trig & i_ap_idle & ~o_ap_start;
    assign rd_nxt    = rd_word >> 8;
    // new byte enters at the top; after BYTES bytes the first one sits in the LSBs
    assign wr_cat    = {i_rx_data, o_mem_wdata};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        bad      = 1'b0;
        trig     = 1'b0;
        wr_word  = 1'b0;
        rd_issue = 1'b0;
        stat_clr = 1'b0;
        if (i_ss_n) begin
            state_d = IDLE;
        end else if (rx) begin
            unique case (state_q)
                IDLE: begin
                    case (i_rx_data)
                        8'h01:   begin op_d = OP_WR;  state_d = ARG; end
                        8'h02:   begin op_d = OP_RD;  state_d = ARG; end
                        8'h04:   begin op_d = OP_RES; state_d = ARG; end
                        8'h03:   state_d = STATUS;
                        8'h05:   trig = 1'b1;
                        default: bad = 1'b1;
                    endcase
                end
                ARG: begin
                    if (op_q == OP_RES) begin
                        if (i_rx_data >= 8'(NUM_RES)) begin
                            bad     = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = RESULT;
                        end
                    end else if (i_rx_data >= 8'(NUM_CH)) begin
                        bad     = 1'b1;
                        state_d = IDLE;
                    end else if (op_q == OP_WR) begin
                        state_d = WRITE;
                    end else begin
                        state_d  = READ;
                        rd_issue = 1'b1;
                    end
                end
                WRITE: begin
                    if (byte_last) begin
                        wr_word = 1'b1;
                        if (word_last) begin
                            state_d = IDLE;
                            trig    = (AUTO_START != 0) && (o_mem_ch == CW'(NUM_CH - 1));
                        end
                    end
                end
                READ: begin
                    if (byte_last) begin
                        if (word_last) state_d = IDLE;
                        else           rd_issue = 1'b1;
                    end
                end
                STATUS: begin
                    stat_clr = 1'b1;
                    state_d  = IDLE;
                end
                RESULT: begin
                    if (byte_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            op_q        <= OP_WR;
            byte_q      <= '0;
            word_q      <= '0;
            rd_word     <= '0;
            rd_pipe     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= '0;
            o_mem_ch    <= '0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_ap_start  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            o_tx_valid <= (state_d == READ) || (state_d == STATUS) || (state_d == RESULT);
            o_mem_we   <= wr_word;
            rd_pipe    <= {rd_pipe[0], rd_issue};
            // a done pulse wins over any clear landing on the same edge
            done_q     <= i_ap_done | (done_q & ~trig_ok & ~stat_clr);
            err_q      <= bad | (trig & ~trig_ok) | (err_q & ~stat_clr);
            if (trig_ok)         o_ap_start <= 1'b1;
            else if (i_ap_ready) o_ap_start <= 1'b0;

            if (rx) begin
                case (state_q)
                    ARG: begin
                        byte_q     <= '0;
                        word_q     <= '0;
                        o_mem_addr <= '0;
                        if (op_q == OP_RES) begin
                            rd_word   <= res_q[i_rx_data[RW-1:0]];
                            o_tx_data <= res_q[i_rx_data[RW-1:0]][7:0];
                        end else begin
                            o_mem_ch <= i_rx_data[CW-1:0];
                        end
                    end
                    WRITE: begin
                        o_mem_wdata <= wr_cat[DATA_W+7:8];
                        byte_q      <= byte_last ? '0 : byte_q + 1'b1;
                        if (byte_last) begin
                            o_mem_addr <= word_q;
                            word_q     <= word_q + 1'b1;
                        end
                    end
                    READ, RESULT: begin
                        byte_q    <= byte_last ? '0 : byte_q + 1'b1;
                        rd_word   <= rd_nxt;
                        o_tx_data <= rd_nxt[7:0];
                        if (byte_last && state_q == READ) begin
                            word_q     <= word_q + 1'b1;
                            o_mem_addr <= word_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // memory word arrives two edges after its address was issued
            if (rd_pipe[1] && state_q == READ) begin
                rd_word   <= i_mem_rdata;
                o_tx_data <= i_mem_rdata[7:0];
            end
            if (state_d == STATUS) o_tx_data <= {5'b0, err_q, busy, done_q};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_q <= '0;
        end else begin
            for (int k = 0; k < NUM_RES; k++)
                if (i_result_vld[k]) res_q[k] <= i_result[k*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_spi_hls_bridge.sv
// Scoreboard bench for spi_hls_bridge: stimulus pushes expected strobes/response bytes,
// independent negedge monitors pop and compare them.
module tb_spi_hls_bridge;
    localparam int DW = 32, DEP = 4, NCH = 3, NRES = 2, BY = DW / 8;

    logic              i_clk = 1'b0, i_rst = 1'b1;
    logic              i_rx_valid = 1'b0, i_ss_n = 1'b0;
    logic [7:0]        i_rx_data = '0;
    logic              o_tx_valid, o_mem_we, o_ap_start;
    logic [7:0]        o_tx_data;
    logic [1:0]        o_mem_ch, o_mem_addr;
    logic [DW-1:0]     o_mem_wdata, i_mem_rdata;
    logic              i_ap_ready = 1'b0, i_ap_done = 1'b0, i_ap_idle = 1'b1;
    logic [NRES*DW-1:0] i_result = '0;
    logic [NRES-1:0]   i_result_vld = '0;

    spi_hls_bridge #(.DATA_W(DW), .DEPTH(DEP), .NUM_CH(NCH), .NUM_RES(NRES), .AUTO_START(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .i_ss_n(i_ss_n), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_mem_ch(o_mem_ch),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_ap_start(o_ap_start), .i_ap_ready(i_ap_ready),
        .i_ap_done(i_ap_done), .i_ap_idle(i_ap_idle), .i_result(i_result),
        .i_result_vld(i_result_vld));

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0]    ch;
        logic [1:0]    addr;
        logic [DW-1:0] data;
        logic          rise;
    } wr_t;

    wr_t           wq[$];
    logic [7:0]    tq[$];
    logic [DW-1:0] ref_mem [NCH][DEP];
    logic [DW-1:0] ref_res [NRES];
    logic [DW-1:0] env_mem [NCH][DEP];
    bit            m_err = 0, m_done = 0, m_start = 0, rx_expect = 0;
    int            exp_starts = 0, n_starts = 0, checks = 0, failures = 0;
    logic          ap_prev = 1'b0;
    wr_t           mon_w;
    logic [7:0]    mon_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // accelerator-side memory the bridge reads and writes
    always @(posedge i_clk) begin
        if (o_mem_we && int'(o_mem_ch) < NCH) env_mem[o_mem_ch][o_mem_addr] <= o_mem_wdata;
        i_mem_rdata <= (int'(o_mem_ch) < NCH) ? env_mem[o_mem_ch][o_mem_addr] : '0;
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_mem_we) begin
                if (wq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected: got ch=%0d addr=%0d data=%0h expected no strobe",
                             o_mem_ch, o_mem_addr, o_mem_wdata);
                end else begin
                    mon_w = wq.pop_front();
                    chk("mem_write", {o_mem_ch, o_mem_addr, o_mem_wdata, o_ap_start & ~ap_prev}, mon_w);
                end
            end
            if (o_ap_start && !ap_prev) n_starts++;
            ap_prev = o_ap_start;
            if (i_rx_valid && !i_ss_n) begin
                if (o_tx_valid) begin
                    if (tq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL tx_unexpected: got %0h expected no response", o_tx_data);
                    end else begin
                        mon_b = tq.pop_front();
                        chk("tx_byte", o_tx_data, mon_b);
                    end
                end else if (rx_expect) begin
                    mon_b = tq.pop_front();
                    checks++; failures++;
                    $display("FAIL tx_missing: got tx_valid=0 expected byte %0h", mon_b);
                end
            end
        end
    end

    // master spacing puts each next byte in the third cycle after the previous pulse
    task automatic send(input logic [7:0] b, input bit rsp = 0, input logic [7:0] exp = 8'h00);
        if (rsp) tq.push_back(exp);
        rx_expect  = rsp;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
        rx_expect  = 0;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic trig_model(output bit acc);
        acc = 0;
        if (i_ap_idle && !m_start) begin
            acc = 1; m_start = 1; m_done = 0; exp_starts++;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic wr_frame(input int ch, input bit rnd, input logic [7:0] base, input int nb);
        logic [DW-1:0] w;
        logic [7:0]    b;
        bit            acc;
        send(8'h01);
        send(8'(ch));
        if (ch >= NCH) begin
            m_err = 1;
            return;
        end
        w = '0;
        for (int i = 0; i < nb; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            w[(i % BY)*8 +: 8] = b;
            if (i % BY == BY - 1) begin
                acc = 0;
                if (ch == NCH - 1 && i == DEP*BY - 1) trig_model(acc);
                wq.push_back('{2'(ch), 2'(i / BY), w, acc});
                ref_mem[ch][i / BY] = w;
            end
            send(b);
        end
        if (nb < DEP*BY) begin
            i_ss_n = 1'b1;
            repeat (2) @(posedge i_clk);
            #1 i_ss_n = 1'b0;
        end
    endtask

    task automatic rd_frame(input int ch);
        send(8'h02);
        send(8'(ch));
        for (int w = 0; w < DEP; w++)
            for (int b = 0; b < BY; b++)
                send(8'($urandom), 1, ref_mem[ch][w][b*8 +: 8]);
    endtask

    task automatic status_cmd();
        logic [7:0] s;
        send(8'h03);
        s = {5'b0, m_err, m_start | ~i_ap_idle, m_done};
        send(8'h00, 1, s);
        m_err  = 0;
        m_done = 0;
    endtask

    task automatic res_cmd(input int idx);
        send(8'h04);
        send(8'(idx));
        for (int b = 0; b < BY; b++) send(8'($urandom), 1, ref_res[idx][b*8 +: 8]);
    endtask

    task automatic start_cmd();
        bit acc;
        trig_model(acc);
        send(8'h05);
    endtask

    task automatic ap_accept(input bit run);
        i_ap_ready = 1'b1;
        i_ap_idle  = ~run;
        @(posedge i_clk); #1;
        i_ap_ready = 1'b0;
        m_start    = 0;
    endtask

    task automatic ap_finish();
        i_ap_done = 1'b1;
        i_ap_idle = 1'b1;
        @(posedge i_clk); #1;
        i_ap_done = 1'b0;
        m_done    = 1;
    endtask

    task automatic cap(input int k, input logic [DW-1:0] v);
        i_result[k*DW +: DW] = v;
        i_result_vld[k]      = 1'b1;
        @(posedge i_clk); #1;
        i_result_vld = '0;
        ref_res[k]   = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NCH; c++) for (int w = 0; w < DEP; w++) ref_mem[c][w] = '0;
        for (int k = 0; k < NRES; k++) ref_res[k] = '0;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_mem_ch", o_mem_ch, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_ap_start", o_ap_start, 0);
        @(posedge i_clk); #1 i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        status_cmd();                      // 0x00 after reset
        res_cmd(0);                        // result regs reset to zero

        wr_frame(0, 0, 8'h01, DEP*BY);     // word0 = 0x04030201, no start
        chk("no_start_ch0", n_starts, 0);

        wr_frame(1, 0, 8'hA0, DEP*BY);
        rd_frame(1);

        wr_frame(2, 0, 8'h40, DEP*BY);     // auto start with last strobe
        chk("ap_start_hold0", o_ap_start, 1);
        status_cmd();                      // 0x02
        chk("ap_start_hold1", o_ap_start, 1);
        ap_accept(1);
        chk("ap_start_clear", o_ap_start, 0);
        status_cmd();                      // 0x02 while running
        ap_finish();
        status_cmd();                      // 0x01
        status_cmd();                      // 0x00

        send(8'h07); m_err = 1;
        status_cmd();                      // 0x04
        wr_frame(3, 0, 8'h00, DEP*BY);     // bad channel, no strobe
        status_cmd();                      // 0x04

        wr_frame(0, 0, 8'h60, 6);          // aborted after 6 bytes: one strobe
        status_cmd();                      // decodes normally
        rd_frame(0);

        cap(1, 32'hDEADBEEF);
        cap(0, 32'h12345678);
        res_cmd(1);                        // EF BE AD DE
        res_cmd(0);
        start_cmd();                       // accepted
        start_cmd();                       // busy -> err, ignored
        status_cmd();                      // 0x06
        ap_accept(1);
        start_cmd();                       // core not idle -> err
        status_cmd();
        ap_finish();
        status_cmd();
        chk("start_count", n_starts, exp_starts);

        for (int it = 0; it < 40; it++) begin
            int op, ch, nb;
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    ch = $urandom_range(0, NCH);
                    nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEP*BY - 1) : DEP*BY;
                    wr_frame(ch, 1, 8'h00, nb);
                    if (m_start) ap_accept(0);
                end
                1: rd_frame($urandom_range(0, NCH - 1));
                2: cap($urandom_range(0, NRES - 1), $urandom);
                3: res_cmd($urandom_range(0, NRES - 1));
                default: status_cmd();
            endcase
        end

        repeat (5) @(posedge i_clk);
        #1;
        chk("wq_drained", wq.size(), 0);
        chk("tq_drained", tq.size(), 0);
        chk("start_count_final", n_starts, exp_starts);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_hls_bridge.md
SPI_HLS_BRIDGE -- requirements
Module: spi_hls_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning memory/result word width in bits: multiple of 8, range 8..64; BYTES = DATA_W/8.
REQ-002 SHALL have parameter DEPTH, default 10, meaning words per channel, 2..256; AW = max(1, clog2(DEPTH)).
REQ-003 SHALL have parameter NUM_CH, default 2, meaning input channels, 1..8; CW = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter NUM_RES, default 2, meaning result registers, 1..8.
REQ-005 SHALL have parameter AUTO_START, default 1, meaning: start the accelerator when a WRITE to channel NUM_CH-1 completes.
REQ-006 SHALL have one clock and an asynchronous, active-high reset; port names and directions follow.
REQ-007 SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_rx_valid  in  1  one-cycle pulse, SPI byte received.
- i_rx_data  in  8  received byte.
- i_ss_n  in  1  SPI select, high = frame inactive.
- o_tx_valid  out  1  response byte valid.
- o_tx_data  out  8  response byte.
- o_mem_ch  out  CW  memory channel select.
- o_mem_addr  out  AW  memory word address.
- o_mem_we  out  1  one-cycle write strobe.
- o_mem_wdata  out  DATA_W  write word.
- i_mem_rdata  in  DATA_W  read word of o_mem_ch/o_mem_addr, 1-cycle latency.
- o_ap_start  out  1  accelerator start.
- i_ap_ready  in  1  accelerator accepted start.
- i_ap_done  in  1  accelerator done pulse.
- i_ap_idle  in  1  accelerator idle.
- i_result  in  NUM_RES*DATA_W  result k at bits [k*DATA_W +: DATA_W].
- i_result_vld  in  NUM_RES  per-result capture strobe.

Function
REQ-008 SHALL implement FSM states IDLE, ARG, WRITE, READ, STATUS, RESULT; in IDLE the next i_rx_valid byte is the command.
REQ-009 SHALL decode commands: 0x01 WRITE, 0x02 READ, 0x04 RESULT (all go to ARG), 0x03 to STATUS, 0x05 START (stays IDLE); any other value sets err_flag, stays IDLE.
REQ-010 SHALL, in ARG, take the next byte as channel (WRITE/READ) or result index (RESULT); value >= NUM_CH (resp. NUM_RES) sets err_flag and returns IDLE.
REQ-011 SHALL, in WRITE, assemble bytes little-endian into a DATA_W word; on the BYTES-th byte pulse o_mem_we for exactly one cycle with o_mem_addr = word index, starting at 0.
REQ-012 SHALL return to IDLE from WRITE after word DEPTH-1 is written; if AUTO_START=1 and channel == NUM_CH-1, raise start trigger on the same cycle as that write strobe.
REQ-013 SHALL, in READ, return DEPTH*BYTES bytes, little-endian, word 0 first, prefetching so each byte is on o_tx_data no later than 3 i_clk cycles after the previous i_rx_valid; return IDLE after the last byte.
REQ-014 SHALL, in STATUS, return one byte {5'b0, err_flag, busy, done_flag}; that byte's i_rx_valid clears done_flag and err_flag and returns IDLE.
REQ-015 SHALL, in RESULT, return BYTES bytes of captured result[index], LSB first, then return IDLE.
REQ-016 SHALL set o_tx_valid=1 in READ, STATUS and RESULT, and 0 elsewhere; o_tx_data is don't-care when o_tx_valid=0.
REQ-017 SHALL treat START command or AUTO_START as a start trigger: if i_ap_idle=1 and o_ap_start=0, set o_ap_start; otherwise set err_flag and ignore the trigger.
REQ-018 SHALL hold o_ap_start high until sampled with i_ap_ready=1, then clear it on the next edge.
REQ-019 SHALL compute busy = o_ap_start | ~i_ap_idle.
REQ-020 SHALL set done_flag on i_ap_done and clear it on an accepted start trigger; set has priority over any same-cycle clear.
REQ-021 SHALL capture result k from i_result on each i_result_vld[k]=1, independent of FSM state.
REQ-022 SHALL, on i_ss_n=1 in any non-IDLE state, return to IDLE next cycle and discard any partial word; completed writes stay written, and no strobe is issued for the partial word.
REQ-023 SHALL ignore i_rx_valid bytes while i_ss_n=1.

Reset
REQ-024 SHALL, while i_rst=1 (asynchronous assertion), force FSM=IDLE and drive o_tx_valid, o_tx_data, o_mem_we, o_mem_ch, o_mem_addr, o_mem_wdata and o_ap_start to 0; done_flag, err_flag, byte/word counters and all result registers also reset to 0.

Verification
REQ-025 SHALL cover: NUM_CH=3, DEPTH=4, DATA_W=32; WRITE ch0, bytes 0x01..0x10 -> 4 strobes at addr 0..3, word0 = 0x04030201, no start.
REQ-026 SHALL cover: WRITE ch2 completes with i_ap_idle=1 -> o_ap_start rises with the last strobe and holds until i_ap_ready; STATUS before done -> 0x02, after i_ap_done -> 0x01, repeat STATUS -> 0x00.
REQ-027 SHALL cover: READ ch1 after writing 0xA0..0xAF -> MISO bytes 0xA0..0xAF in order, with the per-byte timing of REQ-013.
REQ-028 SHALL cover: command 0x07, or WRITE with channel 3 -> no memory strobe; STATUS -> 0x04.
REQ-029 SHALL cover: i_ss_n raised after 6 bytes of WRITE -> exactly 1 strobe; next command decodes normally.
REQ-030 SHALL cover: i_result_vld[1]=1 with result 0xDEADBEEF, then RESULT idx1 -> bytes EF BE AD DE; START while busy -> err_flag=1, no second start.
